vlog_tf_accum: RTL and testbench



---
 rtl/vlog_tf_accum.sv | 221 ++++++++++++++++++++++
 tb/tb_vlog_tf_accum.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlog_tf_accum.sv
// ----------------------------------------------------------------------------
// vlog_tf_accum
//
// Multi-channel arithmetic accumulator. Each accepted command updates one
// per-channel accumulator. READ pushes {channel, value, ovf} into a small
// output FIFO that has valid/ready flow control, then clears the accumulator.
//
// Optional feature (macro VLOG_TF_ACCUM_SATURATE_EN):
//   defined   - ADD/DOUBLE saturate at 2^WIDTH-1 and set a sticky per-channel
//               ovf flag. READ reports and clears it, LOAD clears it.
//   undefined - wrapping arithmetic, no ovf storage, out_ovf tied 0.
//
// Parameters:
//   WIDTH      data/accumulator width (>=2)
//   CHANNELS   number of accumulators (>=1, power of two)
//   FIFO_DEPTH output FIFO entries (>=1)
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready   command handshake (in_ready = FIFO not full)
//   in_op               00=ADD 01=DOUBLE 10=LOAD 11=READ
//   in_chan, in_x, in_y target channel and operands (in_y used by ADD only)
//   out_valid/out_ready result handshake (FIFO head)
//   out_chan, out_data  channel and value of the head result
//   out_ovf             overflow flag of the head result
// ----------------------------------------------------------------------------
module vlog_tf_accum #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [1:0]                                        in_op,
  input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0]    in_chan,
  input  logic [WIDTH-1:0]                                  in_x,
  input  logic [WIDTH-1:0]                                  in_y,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0]    out_chan,
  output logic [WIDTH-1:0]                                  out_data,
  output logic                                              out_ovf
);

  localparam int CW   = $clog2(CHANNELS > 1 ? CHANNELS : 2);
  localparam int PW   = $clog2(FIFO_DEPTH > 1 ? FIFO_DEPTH : 2);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_DOUBLE = 2'b01,
    OP_LOAD   = 2'b10,
    OP_READ   = 2'b11
  } op_e;

  // --------------------------------------------------------------------------
  // Arithmetic helpers. Both return {ovf, value}; the ovf bit is always 0 in
  // the wrapping build.
  // --------------------------------------------------------------------------
`ifdef VLOG_TF_ACCUM_SATURATE_EN
  function automatic logic [WIDTH:0] sum_fn(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : t;
  endfunction

  function automatic logic [WIDTH:0] double_fn(input logic [WIDTH-1:0] a);
    return a[WIDTH-1] ? {1'b1, {WIDTH{1'b1}}} : {1'b0, a[WIDTH-2:0], 1'b0};
  endfunction
`else
  function automatic logic [WIDTH:0] sum_fn(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    t = a + b;
    return {1'b0, t};
  endfunction

  function automatic logic [WIDTH:0] double_fn(input logic [WIDTH-1:0] a);
    return {1'b0, a[WIDTH-2:0], 1'b0};
  endfunction
`endif

  // READ returns the pre-clear value and ovf, and yields the cleared value.
  task automatic read_entry(input  logic [WIDTH-1:0] acc_val,
                            input  logic             ovf_val,
                            output logic [WIDTH-1:0] data,
                            output logic             ovf,
                            output logic [WIDTH-1:0] acc_clr);
    data    = acc_val;
    ovf     = ovf_val;
    acc_clr = '0;
  endtask

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] acc_q      [CHANNELS];
  logic [WIDTH-1:0] fifo_data  [FIFO_DEPTH];
  logic [CW-1:0]    fifo_chan  [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]  count;

  logic             accept, push, pop;
  logic [WIDTH-1:0] acc_cur, acc_nxt, push_data;
  logic             ovf_cur, ovf_nxt, push_ovf;
  logic [WIDTH:0]   r_inner, r_outer;

  assign in_ready  = (count != CNTW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (op_e'(in_op) == OP_READ);
  assign pop       = out_valid && out_ready;

  assign acc_cur   = acc_q[in_chan];
  assign out_data  = fifo_data[rd_ptr];
  assign out_chan  = fifo_chan[rd_ptr];

  // --------------------------------------------------------------------------
  // Next value of the addressed accumulator
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so that no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    acc_nxt   = acc_cur;
    ovf_nxt   = ovf_cur;
    push_data = acc_cur;
    push_ovf  = 1'b0;
    r_inner   = '0;
    r_outer   = '0;
    unique case (op_e'(in_op))
      OP_ADD: begin
        r_inner = sum_fn(in_x, in_y);
        r_outer = sum_fn(acc_cur, r_inner[WIDTH-1:0]);
        acc_nxt = r_outer[WIDTH-1:0];
        ovf_nxt = ovf_cur | r_inner[WIDTH] | r_outer[WIDTH];
      end
      OP_DOUBLE: begin
        r_inner = double_fn(in_x);
        r_outer = sum_fn(acc_cur, r_inner[WIDTH-1:0]);
        acc_nxt = r_outer[WIDTH-1:0];
        ovf_nxt = ovf_cur | r_inner[WIDTH] | r_outer[WIDTH];
      end
      OP_LOAD: begin
        acc_nxt = in_x;
        ovf_nxt = 1'b0;
      end
      OP_READ: begin
        read_entry(acc_cur, ovf_cur, push_data, push_ovf, acc_nxt);
        ovf_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Accumulators and FIFO
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the FIFO storage is reset too: the outputs read the head entry
  // directly and must not show X after reset, and the array is tiny.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_chan[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) acc_q[in_chan] <= acc_nxt;
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_chan[wr_ptr] <= in_chan;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leaves count unchanged.
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef VLOG_TF_ACCUM_SATURATE_EN
  // Sticky per-channel overflow flags and the ovf column of the FIFO.
  logic ovf_q     [CHANNELS];
  logic fifo_ovf  [FIFO_DEPTH];

  assign ovf_cur = ovf_q[in_chan];
  assign out_ovf = fifo_ovf[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) ovf_q[c] <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_ovf[i] <= 1'b0;
    end else begin
      if (accept) ovf_q[in_chan] <= ovf_nxt;
      if (push)   fifo_ovf[wr_ptr] <= push_ovf;
    end
  end
`else
  logic unused_ovf;

  assign ovf_cur    = 1'b0;
  assign out_ovf    = 1'b0;
  assign unused_ovf = &{1'b0, ovf_nxt, push_ovf, 1'b0};
`endif

endmodule

// File: tb/tb_vlog_tf_accum.sv
// ----------------------------------------------------------------------------
// tb_vlog_tf_accum
//
// Self-checking bench for vlog_tf_accum (WIDTH=8, CHANNELS=4, FIFO_DEPTH=2).
// A behavioural model of the accumulators pushes the expected result of every
// accepted READ into a scoreboard queue; a monitor pops and compares on every
// output handshake. Follows VLOG_TF_ACCUM_SATURATE_EN for the expected values.
// ----------------------------------------------------------------------------
module tb_vlog_tf_accum;

  localparam int WIDTH      = 8;
  localparam int CHANNELS   = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int CW         = 2;
  localparam int MAXV       = (1 << WIDTH) - 1;

  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] DOUBLE = 2'b01;
  localparam logic [1:0] LOAD   = 2'b10;
  localparam logic [1:0] READ   = 2'b11;

  typedef struct {
    logic [CW-1:0]    chan;
    logic [WIDTH-1:0] data;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [CW-1:0]    in_chan;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_chan;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_acc [CHANNELS];
  bit   m_ovf [CHANNELS];

  always #5 clk = ~clk;

  vlog_tf_accum #(
    .WIDTH     (WIDTH),
    .CHANNELS  (CHANNELS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_chan  (in_chan),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan (out_chan),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  // --------------------------------------------------------------------------
  // Model
  // --------------------------------------------------------------------------
  function automatic void m_add(input int a, input int b, output int r, output bit o);
    int s;
    s = a + b;
`ifdef VLOG_TF_ACCUM_SATURATE_EN
    if (s > MAXV) begin r = MAXV; o = 1'b1; end
    else          begin r = s;    o = 1'b0; end
`else
    r = s % (MAXV + 1);
    o = 1'b0;
`endif
  endfunction

  task automatic model(input logic [1:0] op, input int ch, input int x, input int y);
    int t, r;
    bit o1, o2;
    exp_t e;
    case (op)
      ADD: begin
        m_add(x, y, t, o1);
        m_add(m_acc[ch], t, r, o2);
        m_acc[ch] = r;
        m_ovf[ch] = m_ovf[ch] | o1 | o2;
      end
      DOUBLE: begin
        m_add(x, x, t, o1);
        m_add(m_acc[ch], t, r, o2);
        m_acc[ch] = r;
        m_ovf[ch] = m_ovf[ch] | o1 | o2;
      end
      LOAD: begin
        m_acc[ch] = x;
        m_ovf[ch] = 1'b0;
      end
      default: begin
        e.chan = CW'(ch);
        e.data = WIDTH'(m_acc[ch]);
        e.ovf  = m_ovf[ch];
        sb.push_back(e);
        m_acc[ch] = 0;
        m_ovf[ch] = 1'b0;
      end
    endcase
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
    end
    sb.delete();
  endtask

  // --------------------------------------------------------------------------
  // Output monitor: a handshake seen at the falling edge completes at the
  // next rising edge.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got chan=%0d data=0x%0h with nothing expected",
                 out_chan, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_chan !== e.chan || out_data !== e.data || out_ovf !== e.ovf) begin
          bad++;
          $display("FAIL out_result: got chan=%0d data=0x%0h ovf=%0b, want chan=%0d data=0x%0h ovf=%0b",
                   out_chan, out_data, out_ovf, e.chan, e.data, e.ovf);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // Presents one command and returns at posedge+1 after it was accepted.
  // in_valid stays high so callers can issue commands back-to-back.
  task automatic send(input logic [1:0] op, input int ch, input int x, input int y);
    int  waited;
    bit  done;
    waited   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_chan  = CW'(ch);
    in_x     = WIDTH'(x);
    in_y     = WIDTH'(y);
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model(op, ch, x, y);
        done = 1'b1;
      end else if (++waited > 100) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready=%0b for 100 cycles, want 1", in_ready);
        in_valid = 1'b0;
        done     = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results still outstanding, want 0", sb.size());
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = ADD;
    in_chan   = '0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    if (in_ready  !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    if (out_chan  !== '0)   begin bad++; $display("FAIL reset_out_chan: got %0d want 0", out_chan); end
    if (out_data  !== '0)   begin bad++; $display("FAIL reset_out_data: got 0x%0h want 0", out_data); end
    if (out_ovf   !== 1'b0) begin bad++; $display("FAIL reset_out_ovf: got %0b want 0", out_ovf); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(LOAD, 0, 5, 0);
    send(ADD,  0, 1, 2);
    send(READ, 0, 0, 0);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL read_latency: out_valid=%0b one edge after READ, want 1", out_valid);
    end
    send(READ, 0, 0, 0);
    idle();
    wait_drain();
  endtask

  task automatic test_double();
    out_ready = 1'b1;
    send(LOAD,   2, 8'h30, 0);
    send(DOUBLE, 2, 8'h90, 0);
    send(READ,   2, 0, 0);
    send(READ,   2, 0, 0);
    idle();
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(LOAD, 1, 1, 0);
    send(LOAD, 2, 2, 0);
    send(LOAD, 3, 3, 0);
    send(READ, 1, 0, 0);
    send(READ, 2, 0, 0);
    // FIFO is now full: a third READ must stall.
    in_valid = 1'b1;
    in_op    = READ;
    in_chan  = CW'(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL full_stall: in_ready=%0b out_valid=%0b, want 0/1", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    // The pop frees space only from the next cycle on.
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL pop_same_cycle: in_ready=%0b while popping from full, want 0", in_ready);
    end
    @(posedge clk);
    #1;
    send(READ, 3, 0, 0);
    idle();
    wait_drain();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    send(LOAD, 0, 10, 0);
    send(LOAD, 1, 20, 0);
    for (int i = 0; i < 6; i++) begin
      send(READ, i % 2, 0, 0);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stream_flow: step %0d in_ready=%0b out_valid=%0b, want 1/1",
                 i, in_ready, out_valid);
      end
    end
    idle();
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(LOAD, 0, 7, 0);
    send(READ, 0, 0, 0);
    send(LOAD, 1, 9, 0);
    send(READ, 1, 0, 0);
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: out_valid=%0b in_ready=%0b right after reset, want 0/1",
               out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    send(READ, 0, 0, 0);
    send(READ, 1, 0, 0);
    idle();
    wait_drain();
  endtask

  task automatic test_interleave();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(ADD, 0, 1, 1);
      send(ADD, 3, 1, 1);
    end
    for (int c = 0; c < CHANNELS; c++) send(READ, c, 0, 0);
    idle();
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_double();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_interleave();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
